// File: rtl/mspu_pkg.sv
// Shared types and helpers for the memory-access stage: access size, FSM state,
// byte-lane steering and alignment checks.
package mspu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_state_t;

  // Encoding 3 is a word access as well
  function automatic mem_size_t decode_size(input logic [1:0] bytes);
    case (bytes)
      2'd0:    return MEM_BYTE;
      2'd1:    return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input mem_size_t size, input logic [1:0] a);
    case (size)
      MEM_BYTE: return 4'b0001 << a;
      MEM_HALF: return 4'b0011 << {a[1], 1'b0};
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input mem_size_t size, input logic [31:0] w);
    case (size)
      MEM_BYTE: return {4{w[7:0]}};
      MEM_HALF: return {2{w[15:0]}};
      default:  return w;
    endcase
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] a);
    return ((size == MEM_HALF) && a[0]) || ((size == MEM_WORD) && (a != 2'd0));
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Single-outstanding request/grant/response data-memory port.
interface mem_access_if;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_addr, dmem_we, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// load_align: picks the addressed byte/half out of a read word and sign- or
// zero-extends it. Purely combinational so uncached paths can reuse it.
module load_align
  import mspu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_size_t   size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata;
    result  = rdata;
    case (size)
      MEM_BYTE: begin
        shifted = rdata >> {addr_lo, 3'b000};
        result  = {{24{~uns & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        shifted = rdata >> {addr_lo[1], 4'b0000};
        result  = {{16{~uns & shifted[15]}}, shifted[15:0]};
      end
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: load/store stage with byte-lane steering, load alignment and one
// registered write-back beat per instruction. Optional MSPU_MISALIGN_TRAP_EN.
module mem_access
  import mspu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               valid_in,
  input  logic [31:0]        alu_result,
  input  logic               mem_to_reg_in,
  input  logic [1:0]         bytes_in,
  input  logic               unsigned_in,
  input  logic [31:0]        wdata_in,
  input  logic               we_in,
  input  logic               re_in,
  input  logic [4:0]         rd_in,
  input  logic               reg_we_in,
  output logic               stall,
  mem_access_if.master       dmem,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic               wb_we,
  output logic [31:0]        wb_data,
  output logic               misalign_err
);

  mem_state_t  state_q, state_d;

  // Instruction captured at acceptance
  logic [31:0] addr_q, addr_d;
  mem_size_t   size_q, size_d;
  logic        uns_q, uns_d;
  logic        m2r_q, m2r_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwe_q, regwe_d;
  logic        store_q, store_d;

  logic        req_q, req_d;
  logic [31:0] daddr_q, daddr_d;
  logic        dwe_q, dwe_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] dwdata_q, dwdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;

  mem_size_t   size_in;
  logic        accept, is_mem, misalign_in;
  logic [31:0] aligned, load_wb;

  assign size_in = decode_size(bytes_in);
  assign accept  = (state_q == IDLE) && run && valid_in;
  assign is_mem  = we_in | re_in;

`ifdef MSPU_MISALIGN_TRAP_EN
  assign misalign_in = is_mem && is_misaligned(size_in, alu_result[1:0]);
`else
  assign misalign_in = 1'b0;
`endif

  load_align u_load_align (
    .rdata   (dmem.dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .result  (aligned)
  );

  assign load_wb = m2r_q ? aligned : addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    m2r_d      = m2r_q;
    rd_d       = rd_q;
    regwe_d    = regwe_q;
    store_d    = store_q;
    req_d      = req_q;
    daddr_d    = daddr_q;
    dwe_d      = dwe_q;
    be_d       = be_q;
    dwdata_d   = dwdata_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = alu_result;
          size_d  = size_in;
          uns_d   = unsigned_in;
          m2r_d   = mem_to_reg_in;
          rd_d    = rd_in;
          regwe_d = reg_we_in;
          store_d = we_in;
          if (!is_mem || misalign_in) begin
            // Completes without touching the bus; a trapped access never writes rd
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_in;
            wb_we_d    = reg_we_in & ~misalign_in;
            wb_data_d  = alu_result;
            misalign_d = misalign_in;
          end else begin
            state_d  = REQ;
            req_d    = 1'b1;
            daddr_d  = {alu_result[31:2], 2'b00};
            dwe_d    = we_in;
            be_d     = byte_enables(size_in, alu_result[1:0]);
            dwdata_d = store_lanes(size_in, wdata_in);
          end
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          req_d = 1'b0;
          if (store_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_we_d    = regwe_q;
            wb_data_d  = addr_q;
          end else if (dmem.dmem_rvalid) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_we_d    = regwe_q;
            wb_data_d  = load_wb;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (dmem.dmem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = regwe_q;
          wb_data_d  = load_wb;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      daddr_q    <= '0;
      dwe_q      <= 1'b0;
      be_q       <= '0;
      dwdata_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      daddr_q    <= daddr_d;
      dwe_q      <= dwe_d;
      be_q       <= be_d;
      dwdata_q   <= dwdata_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
    addr_q  <= addr_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    m2r_q   <= m2r_d;
    rd_q    <= rd_d;
    regwe_q <= regwe_d;
    store_q <= store_d;
  end

  assign stall           = (state_q != IDLE);
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_addr  = daddr_q;
  assign dmem.dmem_we    = dwe_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = dwdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_rd           = wb_rd_q;
  assign wb_we           = wb_we_q;
  assign wb_data         = wb_data_q;
  assign misalign_err    = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a lane-level reference model; honours
// MSPU_MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset, run, valid_in, mem_to_reg_in, unsigned_in, we_in, re_in, reg_we_in;
  logic [31:0] alu_result, wdata_in;
  logic [1:0]  bytes_in;
  logic [4:0]  rd_in;
  logic        stall, wb_valid, wb_we, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          n_vec = 0;
  int          n_err = 0;

  mem_access_if dmem ();

  mem_access u_dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .valid_in      (valid_in),
    .alu_result    (alu_result),
    .mem_to_reg_in (mem_to_reg_in),
    .bytes_in      (bytes_in),
    .unsigned_in   (unsigned_in),
    .wdata_in      (wdata_in),
    .we_in         (we_in),
    .re_in         (re_in),
    .rd_in         (rd_in),
    .reg_we_in     (reg_we_in),
    .stall         (stall),
    .dmem          (dmem),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic        m2r;
    logic [1:0]  bytes;
    logic        uns;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [4:0]  rd;
    logic        regwe;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
  } op_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input logic [31:0] alu, input logic m2r, input logic [1:0] bytes,
                             input logic uns, input logic [31:0] wdata, input logic we,
                             input logic re, input logic [4:0] rd, input logic regwe,
                             input int gd, input int rvd, input logic [31:0] rdata);
    op_t o;
    o.alu = alu; o.m2r = m2r; o.bytes = bytes; o.uns = uns; o.wdata = wdata;
    o.we = we; o.re = re; o.rd = rd; o.regwe = regwe;
    o.gnt_dly = gd; o.rv_dly = rvd; o.rdata = rdata;
    return o;
  endfunction

  function automatic int op_size(input logic [1:0] b);
    return (b == 2'd0) ? 1 : (b == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic op_misaligned(input op_t o);
`ifdef MSPU_MISALIGN_TRAP_EN
    int sz;
    sz = op_size(o.bytes);
    return (o.we || o.re) && ((o.alu % sz) != 0);
`else
    return (o.alu == 32'h0) && 1'b0;
`endif
  endfunction

  // First byte lane covered by the access
  function automatic int lane_base(input op_t o);
    int sz;
    sz = op_size(o.bytes);
    return (sz == 4) ? 0 : (int'(o.alu[1:0]) / sz) * sz;
  endfunction

  function automatic logic [3:0] exp_be(input op_t o);
    logic [3:0] be;
    int sz, b;
    sz = op_size(o.bytes);
    b  = lane_base(o);
    for (int i = 0; i < 4; i++) be[i] = (i >= b) && (i < b + sz);
    return be;
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o);
    logic [31:0] w;
    int sz;
    sz = op_size(o.bytes);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = o.wdata[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input op_t o);
    logic [31:0] v, mask;
    int sz;
    sz = op_size(o.bytes);
    v  = o.rdata >> (8 * lane_base(o));
    if (sz < 4) begin
      mask = (32'h1 << (8 * sz)) - 32'h1;
      v = v & mask;
      if (!o.uns && v[8*sz-1]) v = v | ~mask;
    end
    return o.m2r ? v : o.alu;
  endfunction

  task automatic drive(input op_t o);
    alu_result = o.alu; mem_to_reg_in = o.m2r; bytes_in = o.bytes; unsigned_in = o.uns;
    wdata_in = o.wdata; we_in = o.we; re_in = o.re; rd_in = o.rd; reg_we_in = o.regwe;
  endtask

  // Upstream noise while the stage is busy; none of it may be accepted
  task automatic set_garbage();
    valid_in = 1'($urandom_range(0, 1)); run = 1'($urandom_range(0, 1));
    alu_result = $urandom; wdata_in = $urandom; bytes_in = 2'($urandom);
    rd_in = 5'($urandom); reg_we_in = 1'($urandom); we_in = 1'($urandom);
    re_in = 1'($urandom); mem_to_reg_in = 1'($urandom); unsigned_in = 1'($urandom);
  endtask

  task automatic chk_wb(input string tag, input op_t o, input logic [31:0] data);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_wbrd"}, 32'(wb_rd), 32'(o.rd));
    chk({tag, "_wbwe"}, 32'(wb_we), 32'(o.regwe));
    chk({tag, "_wbdata"}, wb_data, data);
    chk({tag, "_mis"}, 32'(misalign_err), 32'd0);
    chk({tag, "_req"}, 32'(dmem.dmem_req), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_op(input op_t o);
    logic mis, mem;
    mis = op_misaligned(o);
    mem = o.we | o.re;
    if ($urandom_range(0, 3) == 0) begin
      drive(o); run = 1'b0; valid_in = 1'b1;
      @(negedge clk);
      chk("norun_wbv", 32'(wb_valid), 32'd0);
      chk("norun_req", 32'(dmem.dmem_req), 32'd0);
    end
    drive(o); run = 1'b1; valid_in = 1'b1;
    chk("acc_stall", 32'(stall), 32'd0);
    @(negedge clk);
    if (!mem) begin
      chk_wb("alu", o, o.alu);
      valid_in = 1'b0; run = 1'b1;
      return;
    end
    if (mis) begin
      chk("trap_wbv", 32'(wb_valid), 32'd1);
      chk("trap_wbwe", 32'(wb_we), 32'd0);
      chk("trap_mis", 32'(misalign_err), 32'd1);
      chk("trap_req", 32'(dmem.dmem_req), 32'd0);
      valid_in = 1'b0; run = 1'b1;
      return;
    end
    chk("req", 32'(dmem.dmem_req), 32'd1);
    chk("addr", dmem.dmem_addr, o.alu & 32'hFFFF_FFFC);
    chk("we", 32'(dmem.dmem_we), 32'(o.we));
    chk("be", 32'(dmem.dmem_be), 32'(exp_be(o)));
    if (o.we) chk("wdata", dmem.dmem_wdata, exp_wdata(o));
    chk("req_stall", 32'(stall), 32'd1);
    chk("req_wbv", 32'(wb_valid), 32'd0);
    set_garbage();
    for (int k = 0; k < o.gnt_dly; k++) begin
      dmem.dmem_gnt = 1'b0;
      dmem.dmem_rvalid = 1'($urandom_range(0, 1));
      dmem.dmem_rdata = $urandom;
      @(negedge clk);
      chk("hold_req", 32'(dmem.dmem_req), 32'd1);
      chk("hold_addr", dmem.dmem_addr, o.alu & 32'hFFFF_FFFC);
      chk("hold_stall", 32'(stall), 32'd1);
      chk("hold_wbv", 32'(wb_valid), 32'd0);
      set_garbage();
    end
    dmem.dmem_gnt = 1'b1;
    dmem.dmem_rvalid = !o.we && (o.rv_dly == 0);
    dmem.dmem_rdata = dmem.dmem_rvalid ? o.rdata : $urandom;
    @(negedge clk);
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
    if (o.we) begin
      chk_wb("st", o, o.alu);
    end else if (o.rv_dly == 0) begin
      chk_wb("ld0", o, exp_load(o));
    end else begin
      chk("wr_stall", 32'(stall), 32'd1);
      chk("wr_req", 32'(dmem.dmem_req), 32'd0);
      chk("wr_wbv", 32'(wb_valid), 32'd0);
      set_garbage();
      for (int k = 1; k <= o.rv_dly; k++) begin
        dmem.dmem_gnt = 1'($urandom_range(0, 1));
        dmem.dmem_rvalid = (k == o.rv_dly);
        dmem.dmem_rdata = (k == o.rv_dly) ? o.rdata : $urandom;
        @(negedge clk);
        if (k < o.rv_dly) chk("wr_busy", 32'({stall, wb_valid}), 32'b10);
        set_garbage();
      end
      dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
      chk_wb("ld", o, exp_load(o));
    end
    valid_in = 1'b0; run = 1'b1;
  endtask

  initial begin
    op_t o;
    reset = 1'b1; run = 1'b0; valid_in = 1'b0;
    alu_result = '0; mem_to_reg_in = 1'b0; bytes_in = '0; unsigned_in = 1'b0;
    wdata_in = '0; we_in = 1'b0; re_in = 1'b0; rd_in = '0; reg_we_in = 1'b0;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(dmem.dmem_req), 32'd0);
    chk("rst_we", 32'(dmem.dmem_we), 32'd0);
    chk("rst_addr", dmem.dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem.dmem_be), 32'd0);
    chk("rst_wdata", dmem.dmem_wdata, 32'd0);
    chk("rst_wb", 32'({wb_valid, wb_we, misalign_err, wb_rd}), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    reset = 1'b0; run = 1'b1;

    do_op(mk(32'h1234, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0, 5'd5, 1'b1, 0, 0, 32'h0));
    do_op(mk(32'h1003, 1'b0, 2'd0, 1'b0, 32'hAB, 1'b1, 1'b0, 5'd0, 1'b0, 3, 0, 32'h0));
    do_op(mk(32'h2002, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd9, 1'b1, 0, 0, 32'h8001_0000));
    do_op(mk(32'h2002, 1'b1, 2'd1, 1'b1, 32'h0, 1'b0, 1'b1, 5'd9, 1'b1, 0, 0, 32'h8001_0000));
    do_op(mk(32'h4001, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd3, 1'b1, 2, 4, 32'h1234_F600));
    do_op(mk(32'h3001, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 5'd4, 1'b1, 0, 0, 32'hCAFE_F00D));
    do_op(mk(32'h5006, 1'b0, 2'd1, 1'b0, 32'h0, 1'b0, 1'b1, 5'd6, 1'b1, 1, 1, 32'h8765_4321));
    do_op(mk(32'h6000, 1'b0, 2'd3, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd7, 1'b0, 0, 0, 32'h0));

    // Reset while waiting for read data
    o = mk(32'h40, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0, 1'b1, 5'd7, 1'b1, 0, 0, 32'h1);
    drive(o); run = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; dmem.dmem_gnt = 1'b1;
    @(negedge clk);
    dmem.dmem_gnt = 1'b0;
    chk("rstw_pre_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstw_req", 32'(dmem.dmem_req), 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_wbv", 32'(wb_valid), 32'd0);
    dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = $urandom;
    @(negedge clk);
    dmem.dmem_rvalid = 1'b0;
    chk("late_rv_wbv", 32'(wb_valid), 32'd0);
    chk("late_rv_stall", 32'(stall), 32'd0);
    do_op(mk(32'h88, 1'b1, 2'd0, 1'b1, 32'h0, 1'b0, 1'b1, 5'd8, 1'b1, 1, 2, 32'h00C3_0000));

    for (int n = 0; n < 250; n++) begin
      o = mk($urandom, 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
             1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      do_op(o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
